mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = memory states wait on mem_ready and 0 = memory is treated as ready every cycle.
REQ-002 SHALL have parameter MEM_TO, default 15, meaning the maximum number of wait cycles (1..255) before a memory timeout.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the retired-instruction counter width.
REQ-004 Ports, clock and reset first:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  6  opcode from the external IR.
- Funct  in  6  funct field from the external IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register-file write enable.
- EXTOp  out  1  1 = sign-extend.
- ALUSrc  out  1  1 = immediate on ALU B.
- ALUOp  out  3  ALU operation code.
- NPCOp  out  2  next-PC select.
- GPRSel  out  2  write-register select.
- WDSel  out  2  write-data select.
- illegal  out  1  1-cycle pulse on an undecodable instruction.
- mem_err  out  1  1-cycle pulse on a memory timeout.
- instr_cnt  out  CNT_W  count of retired instructions.

Function
REQ-005 SHALL decode add, sub, and, or, slt, sltu, addu, subu, sll, addi, ori, lw, sw, beq, j and jal using the standard MIPS Op/Funct values.
REQ-006 Encodings SHALL be as follows:
- ALUOp: NOP=000, ADD=001, SUB=010, AND=011, OR=100, SLT=101, SLTU=110, SLL=111.
- NPCOp: PLUS4=00, BRANCH=01, JUMP=10.
- GPRSel: RD=00, RT=01, R31=10.
- WDSel: ALU=00, MEM=01, PC=10.
REQ-007 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEMACC and WB; all outputs are decoded from the state register plus the live Op/Funct/Zero inputs.
REQ-008 FETCH SHALL drive MemRead=1 and IorD=0; on mem_ready it SHALL drive IRWrite=1, PCWrite=1 and NPCOp=PLUS4, then go to DECODE.
REQ-009 DECODE SHALL handle each instruction class as follows:
- j: PCWrite=1, NPCOp=JUMP, go to FETCH.
- jal: additionally RegWrite=1, GPRSel=R31, WDSel=PC.
- illegal opcode or funct: illegal=1, go to FETCH without retiring.
- all others: go to EXEC.
REQ-010 EXEC SHALL drive ALUOp, ALUSrc and EXTOp per instruction:
- beq: ALUOp=SUB; PCWrite=Zero, NPCOp=BRANCH; go to FETCH.
- lw/sw: go to MEMACC.
- R-type/addi/ori: go to WB.
REQ-011 MEMACC SHALL drive IorD=1 with MemRead=1 (lw) or MemWrite=1 (sw), holding ALUOp=ADD and EXTOp=1; on mem_ready, sw goes to FETCH and lw goes to WB.
REQ-012 WB SHALL drive RegWrite=1, with GPRSel=RD for R-type and RT otherwise, and WDSel=MEM for lw and ALU otherwise; then go to FETCH.
REQ-013 Control outputs not listed for a state SHALL be 0.
REQ-014 Waits in FETCH/MEMACC SHALL hold every output stable; a wait counter increments each non-ready cycle.
- When the counter reaches MEM_TO, the block pulses mem_err, clears the counter and returns to FETCH.
- A timed-out instruction is not retired, and PCWrite/IRWrite/RegWrite are not asserted.
REQ-015 The wait counter SHALL clear on every state change.
REQ-016 When MEM_WAIT_EN=0, mem_ready SHALL be ignored and treated as 1, and mem_err SHALL never assert.
REQ-017 instr_cnt SHALL increment by 1 in the final cycle of each retired instruction and wrap modulo 2^CNT_W.
REQ-018 Latency SHALL be, with zero wait states:
- j/jal: 2 cycles.
- beq: 3 cycles.
- R-type/addi/ori/sw: 4 cycles.
- lw: 5 cycles.
REQ-019 A mem_ready asserted outside FETCH/MEMACC SHALL be ignored.

Reset
REQ-020 rst=1 at a rising edge SHALL force:
- state to FETCH;
- the wait counter and instr_cnt to 0;
- illegal and mem_err to 0.
REQ-021 rst asserted mid-instruction SHALL abandon that instruction, which is not retired; the first post-reset cycle is FETCH with MemRead=1.

Structure
REQ-022 The state, ALUOp, NPCOp, GPRSel and WDSel encodings, plus the Op/Funct constants, SHALL live in the shared package ctrl_pkg.
REQ-023 Instruction decode SHALL be a combinational sub-module mc_decode, which outputs one-hot instruction flags and the illegal flag; mc_ctrl holds the FSM, wait counter and instr_cnt.

Verification
REQ-024 Reset then addu with zero wait states: states F→D→E→W, RegWrite=1 and GPRSel=00 in cycle 4, instr_cnt=1.
REQ-025 lw with mem_ready low for 3 cycles in MEMACC: MemRead and IorD=1 held for 4 cycles, then WB with WDSel=01, total 8 cycles.
REQ-026 beq with Zero=1 then beq with Zero=0: PCWrite=1 with NPCOp=01 in EXEC for the first, PCWrite=0 for the second, instr_cnt +2.
REQ-027 jal: in DECODE, RegWrite=1, GPRSel=10, WDSel=10, NPCOp=10, back to FETCH after 2 cycles.
REQ-028 Op=0x3F: illegal pulses for exactly 1 cycle and instr_cnt unchanged; with MEM_TO=4 and mem_ready held low in FETCH, mem_err pulses on the 4th wait cycle.
REQ-029 rst asserted during MEMACC of sw: MemWrite drops next cycle, state=FETCH, instr_cnt=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, mux selects, Op/Funct values.
// Purely declarative: no latency and no flow control.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMACC = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10} npcop_e;
  typedef enum logic [1:0] {GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_R31 = 2'b10} gprsel_e;
  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10} wdsel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // One-hot instruction flags; all-zero means undecodable.
  typedef struct packed {
    logic add, addu, sub, subu, land, lor, slt, sltu, sll;
    logic addi, ori, lw, sw, beq, j, jal;
  } instr_t;

  function automatic aluop_e alu_of(instr_t f);
    aluop_e op;
    op = ALU_NOP;
    if (f.add | f.addu | f.addi | f.lw | f.sw) op = ALU_ADD;
    else if (f.sub | f.subu | f.beq)           op = ALU_SUB;
    else if (f.land)                           op = ALU_AND;
    else if (f.lor | f.ori)                    op = ALU_OR;
    else if (f.slt)                            op = ALU_SLT;
    else if (f.sltu)                           op = ALU_SLTU;
    else if (f.sll)                            op = ALU_SLL;
    return op;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational Op/Funct decoder producing one-hot instruction flags and an illegal flag.
// Zero latency; no flow control.
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_t     instr_o,
  output logic       illegal_o
);

  always_comb begin
    instr_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  instr_o.add  = 1'b1;
          FN_ADDU: instr_o.addu = 1'b1;
          FN_SUB:  instr_o.sub  = 1'b1;
          FN_SUBU: instr_o.subu = 1'b1;
          FN_AND:  instr_o.land = 1'b1;
          FN_OR:   instr_o.lor  = 1'b1;
          FN_SLT:  instr_o.slt  = 1'b1;
          FN_SLTU: instr_o.sltu = 1'b1;
          FN_SLL:  instr_o.sll  = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: instr_o.addi = 1'b1;
      OP_ORI:  instr_o.ori  = 1'b1;
      OP_LW:   instr_o.lw   = 1'b1;
      OP_SW:   instr_o.sw   = 1'b1;
      OP_BEQ:  instr_o.beq  = 1'b1;
      OP_J:    instr_o.j    = 1'b1;
      OP_JAL:  instr_o.jal  = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = (instr_o == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait/timeout handling and a retired-instruction counter.
// 2-5 cycles per instruction; FETCH/MEMACC stall on mem_ready until MEM_TO wait cycles, then mem_err.
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int MEM_TO      = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             EXTOp,
  output logic             ALUSrc,
  output logic [2:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_t           ins;
  logic             dec_illegal;
  logic             ready, waiting, timeout, retire;

  mc_decode u_decode (
    .op_i      (Op),
    .funct_i   (Funct),
    .instr_o   (ins),
    .illegal_o (dec_illegal)
  );

  assign ready = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_d  = state_q;
    waiting  = 1'b0;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PLUS4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (ins.j || ins.jal) begin
          PCWrite  = 1'b1;
          NPCOp    = NPC_JUMP;
          RegWrite = ins.jal;
          GPRSel   = ins.jal ? GPR_R31 : GPR_RD;
          WDSel    = ins.jal ? WD_PC : WD_ALU;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUOp  = alu_of(ins);
        ALUSrc = ins.addi | ins.ori | ins.lw | ins.sw;
        EXTOp  = ins.addi | ins.lw | ins.sw;
        if (ins.beq) begin
          PCWrite = Zero;
          NPCOp   = NPC_BRANCH;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (ins.lw || ins.sw) begin
          state_d = S_MEMACC;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEMACC: begin
        IorD     = 1'b1;
        MemRead  = ins.lw;
        MemWrite = ins.sw;
        ALUOp    = ALU_ADD;
        EXTOp    = 1'b1;
        if (ready) begin
          retire  = ins.sw;
          state_d = ins.lw ? S_WB : S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (Op == OP_RTYPE) ? GPR_RD : GPR_RT;
        WDSel    = ins.lw ? WD_MEM : WD_ALU;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // The MEM_TO-th consecutive wait cycle aborts the instruction back to FETCH.
    timeout = waiting && (wait_q == TO_LAST);
    if (timeout) begin
      mem_err = 1'b1;
      state_d = S_FETCH;
    end
  end

  assign wait_d    = (waiting && !timeout) ? wait_q + 8'd1 : 8'd0;
  assign cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
  assign instr_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle sequences from a table-driven model.
module tb_mc_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4;
  localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_LW = 3'd2, K_SW = 3'd3,
                         K_BEQ = 3'd4, K_J = 3'd5, K_JAL = 3'd6, K_ILL = 3'd7;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] kind;
    logic [2:0] alu;
    logic       src;
    logic       ext;
  } ins_t;

  typedef struct packed {
    logic       pcw, irw, iord, mrd, mwr, rw, ext, src;
    logic [2:0] alu;
    logic [1:0] npc, gpr, wd;
    logic       ill, merr;
  } ctl_t;

  logic clk = 1'b0;
  logic rst, Zero, mem_ready;
  logic [5:0] Op, Funct;
  logic PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc, illegal, mem_err;
  logic [2:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [CW-1:0] instr_cnt;
  ctl_t got;

  int vectors = 0;
  int miscompares = 0;
  int retired = 0;

  mc_ctrl #(.MEM_WAIT_EN(1), .MEM_TO(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .illegal(illegal), .mem_err(mem_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign got = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc,
                ALUOp, NPCOp, GPRSel, WDSel, illegal, mem_err};

  // Instruction set: opcode, funct, class, ALU operation, immediate on B, sign-extend.
  function automatic ins_t entry(input int i);
    case (i)
      0:       return '{6'h00, 6'h20, K_R,   3'b001, 1'b0, 1'b0};
      1:       return '{6'h00, 6'h22, K_R,   3'b010, 1'b0, 1'b0};
      2:       return '{6'h00, 6'h24, K_R,   3'b011, 1'b0, 1'b0};
      3:       return '{6'h00, 6'h25, K_R,   3'b100, 1'b0, 1'b0};
      4:       return '{6'h00, 6'h2A, K_R,   3'b101, 1'b0, 1'b0};
      5:       return '{6'h00, 6'h2B, K_R,   3'b110, 1'b0, 1'b0};
      6:       return '{6'h00, 6'h21, K_R,   3'b001, 1'b0, 1'b0};
      7:       return '{6'h00, 6'h23, K_R,   3'b010, 1'b0, 1'b0};
      8:       return '{6'h00, 6'h00, K_R,   3'b111, 1'b0, 1'b0};
      9:       return '{6'h08, 6'h15, K_I,   3'b001, 1'b1, 1'b1};
      10:      return '{6'h0D, 6'h2C, K_I,   3'b100, 1'b1, 1'b0};
      11:      return '{6'h23, 6'h07, K_LW,  3'b001, 1'b1, 1'b1};
      12:      return '{6'h2B, 6'h3E, K_SW,  3'b001, 1'b1, 1'b1};
      13:      return '{6'h04, 6'h11, K_BEQ, 3'b010, 1'b0, 1'b0};
      14:      return '{6'h02, 6'h09, K_J,   3'b000, 1'b0, 1'b0};
      15:      return '{6'h03, 6'h1F, K_JAL, 3'b000, 1'b0, 1'b0};
      default: return '{6'h3F, 6'h3F, K_ILL, 3'b000, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic ins_t classify(input logic [5:0] op, input logic [5:0] fn);
    ins_t e;
    for (int i = 0; i < 16; i++) begin
      e = entry(i);
      if (e.op == op && (e.kind != K_R || e.fn == fn)) begin
        e.fn = fn;
        return e;
      end
    end
    return '{op, fn, K_ILL, 3'b000, 1'b0, 1'b0};
  endfunction

  function automatic ctl_t expect_of(input int ph, input ins_t in, input logic rdy, input logic z);
    ctl_t e;
    e = '0;
    case (ph)
      P_FETCH: begin
        e.mrd = 1'b1;
        if (rdy) begin e.irw = 1'b1; e.pcw = 1'b1; end
      end
      P_DEC: begin
        if (in.kind == K_J || in.kind == K_JAL) begin e.pcw = 1'b1; e.npc = 2'b10; end
        if (in.kind == K_JAL) begin e.rw = 1'b1; e.gpr = 2'b10; e.wd = 2'b10; end
        if (in.kind == K_ILL) e.ill = 1'b1;
      end
      P_EXEC: begin
        e.alu = in.alu; e.src = in.src; e.ext = in.ext;
        if (in.kind == K_BEQ) begin e.pcw = z; e.npc = 2'b01; end
      end
      P_MEM: begin
        e.iord = 1'b1; e.alu = 3'b001; e.ext = 1'b1;
        e.mrd = (in.kind == K_LW); e.mwr = (in.kind == K_SW);
      end
      P_WB: begin
        e.rw = 1'b1;
        e.gpr = (in.kind == K_R) ? 2'b00 : 2'b01;
        e.wd = (in.kind == K_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: inputs irrelevant to the phase are randomised to prove they are ignored.
  task automatic step(input string tag, input int ph, input ins_t in, input logic rdy,
                      input logic z, input logic merr);
    ctl_t e;
    @(negedge clk);
    rst       = 1'b0;
    Op        = (ph == P_FETCH) ? 6'($urandom) : in.op;
    Funct     = (ph == P_FETCH) ? 6'($urandom) : in.fn;
    Zero      = (ph == P_EXEC) ? z : 1'($urandom);
    mem_ready = (ph == P_FETCH || ph == P_MEM) ? rdy : 1'($urandom);
    #1;
    e = expect_of(ph, in, rdy, z);
    e.merr = merr;
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s ctl ph=%0d op=%h fn=%h: got=%h expected=%h", tag, ph, in.op, in.fn, got, e);
    end
    vectors++;
    if (instr_cnt !== CW'(retired)) begin
      miscompares++;
      $display("FAIL %s instr_cnt ph=%0d: got=%0d expected=%0d", tag, ph, instr_cnt, CW'(retired));
    end
  endtask

  // Whole instruction with fw wait cycles in FETCH and mw wait cycles in MEMACC.
  task automatic run(input string tag, input ins_t in, input int fw, input int mw, input logic z);
    for (int k = 0; k < fw; k++) step(tag, P_FETCH, in, 1'b0, z, (k % TO) == TO - 1);
    step(tag, P_FETCH, in, 1'b1, z, 1'b0);
    step(tag, P_DEC, in, 1'b0, z, 1'b0);
    if (in.kind == K_ILL) return;
    if (in.kind == K_J || in.kind == K_JAL) begin retired++; return; end
    step(tag, P_EXEC, in, 1'b0, z, 1'b0);
    if (in.kind == K_BEQ) begin retired++; return; end
    if (in.kind == K_LW || in.kind == K_SW) begin
      for (int k = 0; k < mw; k++) begin
        step(tag, P_MEM, in, 1'b0, z, k == TO - 1);
        if (k == TO - 1) return;
      end
      step(tag, P_MEM, in, 1'b1, z, 1'b0);
      if (in.kind == K_SW) begin retired++; return; end
    end
    step(tag, P_WB, in, 1'b0, z, 1'b0);
    retired++;
  endtask

  task automatic test_reset();
    ctl_t e;
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    e = '0;
    e.mrd = 1'b1;
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset ctl: got=%h expected=%h", got, e);
    end
    vectors++;
    if (instr_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset instr_cnt: got=%0d expected=0", instr_cnt);
    end
    retired = 0;
  endtask

  task automatic test_addu();
    run("addu", entry(6), 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run("lw_wait3", entry(11), 0, 3, 1'b0);
  endtask

  task automatic test_beq();
    run("beq_taken", entry(13), 0, 0, 1'b1);
    run("beq_not_taken", entry(13), 0, 0, 1'b0);
  endtask

  task automatic test_jal();
    run("jal", entry(15), 0, 0, 1'b0);
    run("j", entry(14), 1, 0, 1'b1);
  endtask

  task automatic test_illegal();
    run("illegal_op", classify(6'h3F, 6'h20), 0, 0, 1'b0);
    run("illegal_funct", classify(6'h00, 6'h3F), 0, 0, 1'b0);
    run("after_illegal", entry(9), 0, 0, 1'b0);
  endtask

  task automatic test_fetch_timeout();
    run("fetch_to4", entry(6), 4, 0, 1'b0);
    run("fetch_to8", entry(10), 9, 0, 1'b0);
  endtask

  task automatic test_mem_timeout();
    run("sw_to", entry(12), 0, 4, 1'b0);
    run("lw_to", entry(11), 2, 5, 1'b0);
    run("sw_ok", entry(12), 0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) run("b2b", entry(i), 0, 0, 1'($urandom));
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      ins_t in;
      logic [5:0] op, fn;
      if ($urandom_range(0, 9) < 8) begin
        in = entry($urandom_range(0, 15));
        op = in.op;
        fn = (in.kind == K_R) ? in.fn : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run("random", classify(op, fn), $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    ins_t sw;
    ctl_t e;
    sw = entry(12);
    if (retired % (1 << CW) == 0) run("pre_rst", entry(0), 0, 0, 1'b0);
    step("rst_sw", P_FETCH, sw, 1'b1, 1'b0, 1'b0);
    step("rst_sw", P_DEC, sw, 1'b0, 1'b0, 1'b0);
    step("rst_sw", P_EXEC, sw, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    Op = sw.op; Funct = sw.fn; Zero = 1'b0; mem_ready = 1'b1; rst = 1'b1;
    #1;
    e = expect_of(P_MEM, sw, 1'b1, 1'b0);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL rst_memacc ctl: got=%h expected=%h", got, e);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    e = '0;
    e.mrd = 1'b1;
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL rst_fetch ctl: got=%h expected=%h", got, e);
    end
    vectors++;
    if (instr_cnt !== '0) begin
      miscompares++;
      $display("FAIL rst_cnt instr_cnt: got=%0d expected=0", instr_cnt);
    end
    retired = 0;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    step("tail", P_FETCH, entry(0), 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary within the time limit");
    $fatal(1);
  end

endmodule
